snoop_cache_ctrl: RTL

Per-processor MSI cache controller that feeds one processor input of the shared snooping bus and snoops the bus output. It holds a 4-line direct-mapped cache and serves processor reads and writes. On a miss or an upgrade it drives a 9-bit coherence message onto its bus port. It updates line states from messages issued by other requesters and pulses write-backs of Modified data.

---
 rtl/snoop_cache_ctrl_if.sv | 15 +
 rtl/snoop_cache_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/snoop_cache_ctrl_if.sv
// snoop_cache_ctrl_if: processor, bus, memory and write-back signals of one MSI cache controller
interface snoop_cache_ctrl_if;
  logic req_valid, req_write, busy, resp_valid, bus_blocked, mem_ack, wb_valid;
  logic [2:0] req_addr, wb_addr;
  logic [3:0] req_data, resp_data, mem_data, wb_data;
  logic [8:0] bus_out, bus_in;
  modport master (
    output req_valid, req_write, req_addr, req_data, bus_in, bus_blocked, mem_ack, mem_data,
    input  busy, resp_valid, resp_data, bus_out, wb_valid, wb_addr, wb_data
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_data, bus_in, bus_blocked, mem_ack, mem_data,
    output busy, resp_valid, resp_data, bus_out, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl: MSI controller for a 4-line direct-mapped cache on a snooping bus
module snoop_cache_ctrl (
  input  logic clk,
  input  logic rst_n,
  snoop_cache_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUS_REQ, WAIT_MEM} state_t;
  typedef enum logic [1:0] {LI, LS, LM} line_t;
  localparam logic [1:0] RH = 2'b00, RM = 2'b01, WM = 2'b10, INV = 2'b11;
  state_t state, nstate;
  line_t st [4], nst [4];
  line_t sn_nst, ps;
  logic tg [4], ntg [4];
  logic [3:0] dt [4], ndt [4];
  logic pw, npw, vp, nvp, gq, nbusy, nresp, nwb;
  logic [2:0] pa, npa, va, nva, nwa;
  logic [3:0] pd, npd, vd, nvd, nrdata, nwd;
  logic [8:0] gmsg, nbus;
  logic [1:0] sop, si, ri;
  logic gnt, own, sn_hit, sn_wb, acc, hit, victim;
  assign sop = io.bus_in[8:7];
  assign si = io.bus_in[5:4];
  assign ri = io.req_addr[1:0];
  assign gnt = state == BUS_REQ && io.bus_out != {RH, 7'b0} && !io.bus_blocked;
  // our own granted message may echo back on bus_in this cycle or the next
  assign own = (gnt && io.bus_in == io.bus_out) || (gq && io.bus_in == gmsg);
  assign sn_hit = io.bus_in != {RH, 7'b0} && !own && st[si] != LI && tg[si] == io.bus_in[6];
  assign sn_wb = sn_hit && st[si] == LM && (sop == RM || sop == WM);
  assign sn_nst = (sop == RM && st[si] == LM) ? LS :
                  (sop == WM || (sop == INV && st[si] == LS)) ? LI : st[si];
  assign ps = (sn_hit && si == ri) ? sn_nst : st[ri];
  assign acc = io.req_valid && !io.busy && state == IDLE;
  assign hit = ps != LI && tg[ri] == io.req_addr[2];
  assign victim = ps == LM && tg[ri] != io.req_addr[2];
  always_comb begin
    nst = st;
    ntg = tg;
    ndt = dt;
    nstate = state;
    npa = pa;
    npw = pw;
    npd = pd;
    nbus = io.bus_out;
    nresp = 1'b0;
    nrdata = io.resp_data;
    nwb = 1'b0;
    nwa = io.wb_addr;
    nwd = io.wb_data;
    nvp = 1'b0;
    nva = va;
    nvd = vd;
    if (sn_hit) nst[si] = sn_nst;
    if (sn_wb) begin
      nwb = 1'b1;
      nwa = {tg[si], si};
      nwd = dt[si];
    end
    // a deferred victim write-back yields to any snoop write-back
    if (vp && sn_wb) nvp = 1'b1;
    else if (vp) begin
      nwb = 1'b1;
      nwa = va;
      nwd = vd;
    end
    case (state)
      IDLE: if (acc) begin
        npa = io.req_addr;
        npw = io.req_write;
        npd = io.req_data;
        if (hit && (!io.req_write || ps == LM)) begin
          nresp = 1'b1;
          if (io.req_write) ndt[ri] = io.req_data;
          else nrdata = dt[ri];
        end else begin
          nstate = BUS_REQ;
          nbus = hit ? {INV, io.req_addr, 4'h0} :
                 io.req_write ? {WM, io.req_addr, io.req_data} : {RM, io.req_addr, 4'h0};
          if (!hit) nst[ri] = LI;
          if (victim && sn_wb) begin
            nvp = 1'b1;
            nva = {tg[ri], ri};
            nvd = dt[ri];
          end else if (victim) begin
            nwb = 1'b1;
            nwa = {tg[ri], ri};
            nwd = dt[ri];
          end
        end
      end
      BUS_REQ: if (gnt) begin
        nbus = {RH, 7'b0};
        if (io.bus_out[8:7] == INV) begin
          nst[pa[1:0]] = LM;
          ntg[pa[1:0]] = pa[2];
          ndt[pa[1:0]] = pd;
          nstate = IDLE;
          nresp = 1'b1;
        end else nstate = WAIT_MEM;
      end else if (io.bus_out[8:7] == INV && sn_hit && si == pa[1:0] && sn_nst == LI)
        nbus = {WM, pa, pd};
      WAIT_MEM: if (io.mem_ack) begin
        nst[pa[1:0]] = pw ? LM : LS;
        ntg[pa[1:0]] = pa[2];
        ndt[pa[1:0]] = pw ? pd : io.mem_data;
        if (!pw) nrdata = io.mem_data;
        nresp = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    nbusy = nstate != IDLE || state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      st <= '{default: LI};
      tg <= '{default: 1'b0};
      dt <= '{default: 4'h0};
      pa <= '0;
      pw <= 1'b0;
      pd <= '0;
      vp <= 1'b0;
      va <= '0;
      vd <= '0;
      gq <= 1'b0;
      gmsg <= '0;
      io.busy <= 1'b0;
      io.resp_valid <= 1'b0;
      io.resp_data <= '0;
      io.bus_out <= {RH, 7'b0};
      io.wb_valid <= 1'b0;
      io.wb_addr <= '0;
      io.wb_data <= '0;
    end else begin
      state <= nstate;
      st <= nst;
      tg <= ntg;
      dt <= ndt;
      pa <= npa;
      pw <= npw;
      pd <= npd;
      vp <= nvp;
      va <= nva;
      vd <= nvd;
      gq <= gnt;
      gmsg <= io.bus_out;
      io.busy <= nbusy;
      io.resp_valid <= nresp;
      io.resp_data <= nrdata;
      io.bus_out <= nbus;
      io.wb_valid <= nwb;
      io.wb_addr <= nwa;
      io.wb_data <= nwd;
    end
endmodule
